sw_input_conditioner: RTL and testbench

//  Receives the raw switch bus that the bench driver (or board pins) drives onto i_io_sw.

---
 rtl/io_pkg.sv | 18 +
 rtl/sw_debounce_bit.sv | 52 +++++
 rtl/sw_input_conditioner.sv | 56 +++++
 tb/tb_sw_input_conditioner.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared IO constants for the switch input path, used by the RTL and the bench driver.
package io_pkg;

  localparam int SW_WIDTH           = 32;
  localparam int SW_SYNC_STAGES     = 2;
  localparam int SW_DEBOUNCE_CYCLES = 16;

  // A bit is IDLE while its synchronised level matches the accepted level.
  typedef enum logic {
    DB_IDLE   = 1'b0,
    DB_VERIFY = 1'b1
  } db_state_e;

  function automatic int debounce_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter and accepted-level flop.
module sw_debounce_bit
  import io_pkg::*;
#(
  parameter int SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_stable,
  output logic o_update
);

  localparam int CNT_W = debounce_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   stable_reg;
  logic                   sync_out;
  db_state_e              state;

  assign sync_out = sync_reg[SYNC_STAGES-1];
  assign state    = (sync_out == stable_reg) ? DB_IDLE : DB_VERIFY;
  // Combinational so the top can register the pulse and mask alongside the new level.
  assign o_update = (state == DB_VERIFY) && (cnt_reg == CNT_MAX);
  assign o_stable = stable_reg;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync_reg   <= '0;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_raw};
      case (state)
        DB_IDLE: cnt_reg <= '0;
        DB_VERIFY: begin
          if (cnt_reg == CNT_MAX) begin
            stable_reg <= sync_out;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: cnt_reg <= '0;
      endcase
    end
  end

endmodule

// File: rtl/sw_input_conditioner.sv
// Switch bus conditioner: per-bit sync + debounce, sticky change mask with ack, change pulse.
module sw_input_conditioner
  import io_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int SYNC_STAGES     = SW_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_io_sw,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_sw_stable,
  output logic [WIDTH-1:0] o_sw_changed_mask,
  output logic             o_sw_change,
  output logic             o_event_pending
);

  logic [WIDTH-1:0] update_vec;
  logic [WIDTH-1:0] mask_reg;
  logic [WIDTH-1:0] mask_next;
  logic             change_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      sw_debounce_bit #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_raw   (i_io_sw[gi]),
        .o_stable(o_sw_stable[gi]),
        .o_update(update_vec[gi])
      );
    end
  endgenerate

  // Set wins over clear so an update landing on the ack cycle is not lost.
  assign mask_next = (i_ack ? '0 : mask_reg) | update_vec;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mask_reg   <= '0;
      change_reg <= 1'b0;
    end else begin
      mask_reg   <= mask_next;
      change_reg <= |update_vec;
    end
  end

  assign o_sw_changed_mask = mask_reg;
  assign o_sw_change       = change_reg;
  assign o_event_pending   = |mask_reg;

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Directed bench for sw_input_conditioner with a window-based reference model.
module tb_sw_input_conditioner;

  localparam int W = 8;
  localparam int S = 2;
  localparam int D = 4;
  localparam int H = S + D - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sw  = '0;
  logic         ack = 1'b0;
  logic [W-1:0] stable, mask;
  logic         change, pending;

  int n_checks = 0;
  int n_pass   = 0;

  sw_input_conditioner #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_io_sw(sw), .i_ack(ack),
    .o_sw_stable(stable), .o_sw_changed_mask(mask),
    .o_sw_change(change), .o_event_pending(pending)
  );

  always #5 clk = ~clk;

  // Model: a bit flips when the D most recent synchronised samples (raw delayed by S edges)
  // all disagree with the accepted level. hist[i] holds the raw sample from i+1 edges ago.
  logic [W-1:0] hist [H];
  logic [W-1:0] m_stable, m_mask, m_diff;
  logic         m_change;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < H; i++) hist[i] = '0;
      m_stable = '0; m_mask = '0; m_change = 1'b0;
    end else begin
      m_diff = '1;
      for (int j = S - 1; j <= S + D - 2; j++) m_diff = m_diff & (hist[j] ^ m_stable);
      m_change = |m_diff;
      m_stable = m_stable ^ m_diff;
      m_mask   = (ack ? '0 : m_mask) | m_diff;
      for (int i = H - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sw;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk) begin
    #1;
    chk("model_stable",  32'(stable),  32'(m_stable));
    chk("model_mask",    32'(mask),    32'(m_mask));
    chk("model_change",  32'(change),  32'(m_change));
    chk("model_pending", 32'(pending), 32'(|m_mask));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int pulse_at [$];
  logic saw_change;

  initial begin
    step(3);
    chk("reset_stable", 32'(stable), 32'h0);
    chk("reset_mask",   32'(mask),   32'h0);
    chk("reset_change", 32'(change), 32'h0);
    chk("reset_pending",32'(pending),32'h0);

    // 1: A5 appears on the 6th edge after release.
    rst = 1'b0; sw = 8'hA5;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t1_hold_zero", 32'(stable), 32'h0);
    end
    step();
    chk("t1_stable",  32'(stable),  32'hA5);
    chk("t1_change",  32'(change),  32'h1);
    chk("t1_mask",    32'(mask),    32'hA5);
    chk("t1_pending", 32'(pending), 32'h1);
    $display("txn1 stable=%h mask=%h", stable, mask);
    step();
    chk("t1_change_drop", 32'(change), 32'h0);

    // 3: ack clears the mask on the next edge, stable untouched.
    ack = 1'b1; step(); ack = 1'b0;
    chk("t3_mask",    32'(mask),    32'h0);
    chk("t3_pending", 32'(pending), 32'h0);
    chk("t3_stable",  32'(stable),  32'hA5);
    $display("txn3 stable=%h mask=%h", stable, mask);

    // 2: return to 00, clear mask, then a 3-cycle glitch on bit0.
    sw = 8'h00; step(8);
    chk("t2_pre_stable", 32'(stable), 32'h0);
    ack = 1'b1; step(); ack = 1'b0;
    sw = 8'h01; step(3); sw = 8'h00;
    saw_change = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (change) saw_change = 1'b1;
    end
    chk("t2_stable", 32'(stable),     32'h0);
    chk("t2_change", 32'(saw_change), 32'h0);
    chk("t2_mask",   32'(mask),       32'h0);
    $display("txn2 stable=%h mask=%h", stable, mask);

    // 4: ack on the update cycle of bit1.
    sw = 8'h02; step(5);
    chk("t4_pre_stable", 32'(stable), 32'h0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t4_stable", 32'(stable), 32'h02);
    chk("t4_mask",   32'(mask),   32'h02);
    $display("txn4 stable=%h mask=%h", stable, mask);

    // 6: bits 3 and 6 rise two cycles apart (bit1 dropped first).
    sw = 8'h00; step(8);
    ack = 1'b1; step(); ack = 1'b0;
    sw = 8'h08; step(2); sw = 8'h48;
    for (int i = 0; i < 12; i++) begin
      step();
      if (change) pulse_at.push_back(i);
    end
    chk("t6_npulses", 32'(pulse_at.size()), 32'd2);
    if (pulse_at.size() == 2) chk("t6_gap", 32'(pulse_at[1] - pulse_at[0]), 32'd2);
    chk("t6_mask",   32'(mask),   32'h48);
    chk("t6_stable", 32'(stable), 32'h48);
    $display("txn6 stable=%h mask=%h pulses=%0d", stable, mask, pulse_at.size());

    // 5: reset mid-debounce, then full latency from release.
    sw = 8'h00; step(8);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t5_pre_stable", 32'(stable), 32'h0);
    sw = 8'hFF; step(3);
    rst = 1'b1; #1;
    chk("t5_rst_stable", 32'(stable), 32'h0);
    step(2);
    chk("t5_rst_hold", 32'(stable), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("t5_relatency", 32'(stable), 32'h0);
    end
    step();
    chk("t5_stable", 32'(stable), 32'hFF);
    chk("t5_mask",   32'(mask),   32'hFF);
    $display("txn5 stable=%h mask=%h", stable, mask);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
